// File: rtl/psum_streamer_if.sv
// Bundle of the array-side beat handshake and the post-processing drain outputs.
// master = beat source / drain sink, slave = psum_streamer.
interface psum_streamer_if;
   logic         acc_valid;
   logic [383:0] acc_data;
   logic [3:0]   acc_row;
   logic         acc_first;
   logic         acc_last;
   logic         acc_ready;
   logic         ppu_done;
   logic [383:0] partial_sum;
   logic         valid;
   logic         busy;
   logic         sat_flag;

   modport master (
      output acc_valid, acc_data, acc_row, acc_first, acc_last, ppu_done,
      input  acc_ready, partial_sum, valid, busy, sat_flag
   );

   modport slave (
      input  acc_valid, acc_data, acc_row, acc_first, acc_last, ppu_done,
      output acc_ready, partial_sum, valid, busy, sat_flag
   );
endinterface

// File: rtl/psum_streamer.sv
// Accumulates 16 rows of 16x24-bit signed partial sums, then streams the rows out
// in order and waits for the post-processing unit before accepting a new tile.
module psum_streamer (
   input  logic                  clk,
   input  logic                  rst_n,
   psum_streamer_if.slave        bus,
   output logic [1:0]            o_state
);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // Handshake: a beat transfers when acc_valid && acc_ready at a rising clk edge;
   // the drain side (valid/partial_sum) has no backpressure.
   state_t         r_state;
   state_t         w_state_nxt;
   logic [3:0]     r_cnt;
   logic [3:0]     w_cnt_nxt;
   logic           r_valid;
   logic           w_valid_nxt;
   logic [383:0]   r_psum;
   logic [383:0]   w_psum_nxt;
   logic           r_sat;
   logic           w_sat_nxt;
   logic [383:0]   r_buf [16];

   logic           w_accept;
   logic [383:0]   w_row_old;
   logic [383:0]   w_acc_data;
   logic [383:0]   w_wr_data;
   logic [15:0]    w_lane_sat;
   logic           w_sat_any;

   assign w_row_old = r_buf[bus.acc_row];

   // Sign-extend both lanes to 25 bits; a sum whose top two bits differ overflowed.
   genvar g;
   for (g = 0; g < 16; g++) begin : g_lane
      logic [24:0] w_sum;
      assign w_sum = {w_row_old[g*24+23], w_row_old[g*24 +: 24]}
                   + {bus.acc_data[g*24+23], bus.acc_data[g*24 +: 24]};
      assign w_lane_sat[g] = w_sum[24] ^ w_sum[23];
      assign w_acc_data[g*24 +: 24] = w_lane_sat[g] ?
                                      (w_sum[24] ? 24'h800000 : 24'h7FFFFF) :
                                      w_sum[23:0];
   end

   assign w_wr_data = bus.acc_first ? bus.acc_data : w_acc_data;
   assign w_sat_any = ~bus.acc_first & (|w_lane_sat);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_valid_nxt = 1'b0;
      w_psum_nxt  = '0;
      w_sat_nxt   = r_sat;
      w_accept    = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            w_accept = bus.acc_valid;
            if (w_accept && w_sat_any) w_sat_nxt = 1'b1;
            // Row 0 is never the row written by the closing beat, so it can be preloaded.
            if (w_accept && bus.acc_last && (bus.acc_row == 4'd15)) begin
               w_state_nxt = ST_DRAIN;
               w_valid_nxt = 1'b1;
               w_psum_nxt  = r_buf[0];
            end
         end
         ST_DRAIN: begin
            if (r_cnt == 4'd15) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt   = r_cnt + 4'd1;
               w_valid_nxt = 1'b1;
               w_psum_nxt  = r_buf[r_cnt + 4'd1];
            end
         end
         ST_WAIT: begin
            if (bus.ppu_done) begin
               w_state_nxt = ST_ACCUM;
               w_sat_nxt   = 1'b0;
            end
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_psum  <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_valid_nxt;
         r_psum  <= w_psum_nxt;
         r_sat   <= w_sat_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      end else if (w_accept) begin
         r_buf[bus.acc_row] <= w_wr_data;
      end
   end

   assign bus.acc_ready   = (r_state == ST_ACCUM);
   assign bus.busy        = (r_state != ST_ACCUM);
   assign bus.valid       = r_valid;
   assign bus.partial_sum = r_psum;
   assign bus.sat_flag    = r_sat;
   assign o_state         = r_state;

endmodule

// File: tb/tb_psum_streamer.sv
// Directed bench for psum_streamer: tile fill, drain ordering, accumulation,
// saturation, ignored inputs while busy and asynchronous reset mid-drain.
module tb_psum_streamer;

   logic        clk;
   logic        rst_n;
   logic [1:0]  state;
   int          n_pass;
   int          n_checks;

   logic [383:0] exp_q[$];
   logic [383:0] m_buf [16];
   logic [383:0] cap [16];

   psum_streamer_if bus ();

   psum_streamer u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .o_state (state)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [383:0] pat(input int row, input int off);
      logic [383:0] v;
      v = '0;
      for (int j = 0; j < 16; j++) v[j*24 +: 24] = 24'(row*16 + j + off);
      return v;
   endfunction

   function automatic logic [383:0] fill(input int val);
      logic [383:0] v;
      for (int j = 0; j < 16; j++) v[j*24 +: 24] = 24'(val);
      return v;
   endfunction

   function automatic logic [383:0] lane0v(input int val);
      logic [383:0] v;
      v = '0;
      v[23:0] = 24'(val);
      return v;
   endfunction

   function automatic logic [23:0] lane(input logic [383:0] v, input int j);
      return v[j*24 +: 24];
   endfunction

   // reference buffer update with integer clamp
   task automatic model_write(input int row, input bit first, input logic [383:0] data);
      logic signed [23:0] a;
      logic signed [23:0] b;
      int s;
      for (int j = 0; j < 16; j++) begin
         if (first) begin
            m_buf[row][j*24 +: 24] = data[j*24 +: 24];
         end else begin
            a = m_buf[row][j*24 +: 24];
            b = data[j*24 +: 24];
            s = int'(a) + int'(b);
            if (s > 8388607) s = 8388607;
            if (s < -8388608) s = -8388608;
            m_buf[row][j*24 +: 24] = 24'(s);
         end
      end
   endtask

   // driver: one accepted beat; returns at posedge+1
   task automatic beat(input int row, input bit first, input bit last, input logic [383:0] data);
      bus.acc_valid = 1'b1;
      bus.acc_row   = 4'(row);
      bus.acc_first = first;
      bus.acc_last  = last;
      bus.acc_data  = data;
      @(posedge clk); #1;
      bus.acc_valid = 1'b0;
      bus.acc_first = 1'b0;
      bus.acc_last  = 1'b0;
      model_write(row, first, data);
   endtask

   task automatic drain(input int poke_at, input int rst_at);
      logic [383:0] e;
      for (int r = 0; r < 16; r++) exp_q.push_back(m_buf[r]);
      for (int k = 0; k < 16; k++) begin
         e = exp_q.pop_front();
         chk($sformatf("drain_valid_%0d", k), {383'd0, bus.valid}, 384'd1);
         chk($sformatf("drain_data_%0d", k), bus.partial_sum, e);
         cap[k] = bus.partial_sum;
         if (k == 0) begin
            chk("drain_busy", {383'd0, bus.busy}, 384'd1);
            chk("drain_ready", {383'd0, bus.acc_ready}, 384'd0);
            chk("drain_state", {382'd0, state}, 384'd1);
         end
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_valid", {383'd0, bus.valid}, 384'd0);
            chk("rst_psum", bus.partial_sum, 384'd0);
            chk("rst_ready", {383'd0, bus.acc_ready}, 384'd1);
            chk("rst_busy", {383'd0, bus.busy}, 384'd0);
            chk("rst_state", {382'd0, state}, 384'd0);
            chk("rst_sat", {383'd0, bus.sat_flag}, 384'd0);
            exp_q.delete();
            for (int r = 0; r < 16; r++) m_buf[r] = '0;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk("rst_after_valid", {383'd0, bus.valid}, 384'd0);
            return;
         end
         if (k == poke_at) begin
            bus.acc_valid = 1'b1;
            bus.acc_row   = 4'd5;
            bus.acc_first = 1'b1;
            bus.acc_data  = fill(12345);
            bus.ppu_done  = 1'b1;
         end
         @(posedge clk); #1;
         bus.acc_valid = 1'b0;
         bus.acc_first = 1'b0;
         bus.ppu_done  = 1'b0;
      end
      chk("post_drain_valid", {383'd0, bus.valid}, 384'd0);
      chk("post_drain_psum", bus.partial_sum, 384'd0);
      chk("post_drain_state", {382'd0, state}, 384'd2);
   endtask

   task automatic wait_phase(input bit poke, input bit exp_sat);
      chk("wait_busy", {383'd0, bus.busy}, 384'd1);
      chk("wait_sat", {383'd0, bus.sat_flag}, {383'd0, exp_sat});
      if (poke) begin
         bus.acc_valid = 1'b1;
         bus.acc_row   = 4'd7;
         bus.acc_first = 1'b1;
         bus.acc_data  = fill(999);
         repeat (2) @(posedge clk);
         #1;
         bus.acc_valid = 1'b0;
         bus.acc_first = 1'b0;
         chk("wait_poke_state", {382'd0, state}, 384'd2);
         chk("wait_poke_ready", {383'd0, bus.acc_ready}, 384'd0);
         chk("wait_poke_valid", {383'd0, bus.valid}, 384'd0);
      end
      bus.ppu_done = 1'b1;
      @(posedge clk); #1;
      bus.ppu_done = 1'b0;
      chk("exit_busy", {383'd0, bus.busy}, 384'd0);
      chk("exit_ready", {383'd0, bus.acc_ready}, 384'd1);
      chk("exit_state", {382'd0, state}, 384'd0);
      chk("exit_sat", {383'd0, bus.sat_flag}, 384'd0);
   endtask

   initial begin
      n_pass        = 0;
      n_checks      = 0;
      rst_n         = 1'b0;
      bus.acc_valid = 1'b0;
      bus.acc_data  = '0;
      bus.acc_row   = '0;
      bus.acc_first = 1'b0;
      bus.acc_last  = 1'b0;
      bus.ppu_done  = 1'b0;
      for (int r = 0; r < 16; r++) m_buf[r] = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", {383'd0, bus.valid}, 384'd0);
      chk("reset_psum", bus.partial_sum, 384'd0);
      chk("reset_busy", {383'd0, bus.busy}, 384'd0);
      chk("reset_ready", {383'd0, bus.acc_ready}, 384'd1);
      chk("reset_sat", {383'd0, bus.sat_flag}, 384'd0);
      chk("reset_state", {382'd0, state}, 384'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // tile 1: lane value row*16+lane
      for (int r = 0; r < 16; r++) beat(r, 1'b1, r == 15, pat(r, 0));
      drain(-1, -1);
      chk("t1_row5_lane3", {360'd0, lane(cap[5], 3)}, 384'd83);
      chk("t1_row15_lane15", {360'd0, lane(cap[15], 15)}, 384'd255);
      wait_phase(1'b0, 1'b0);

      // tile 2: 100 - 30 on row 3, acc_last on row 3 only accumulates
      beat(3, 1'b1, 1'b0, fill(100));
      beat(3, 1'b0, 1'b1, fill(-30));
      chk("t2_last_row3_busy", {383'd0, bus.busy}, 384'd0);
      chk("t2_last_row3_ready", {383'd0, bus.acc_ready}, 384'd1);
      for (int r = 0; r < 16; r++) if (r != 3) beat(r, 1'b1, r == 15, pat(r, 500));
      drain(4, -1);
      chk("t2_row3_lane0", {360'd0, lane(cap[3], 0)}, 384'd70);
      chk("t2_row3_lane15", {360'd0, lane(cap[3], 15)}, 384'd70);
      wait_phase(1'b1, 1'b0);

      // tile 3: saturation both ways, rows 5/7 must survive earlier pokes
      beat(0, 1'b1, 1'b0, lane0v(8388000));
      chk("t3_sat_before", {383'd0, bus.sat_flag}, 384'd0);
      beat(0, 1'b0, 1'b0, lane0v(1000));
      chk("t3_sat_pos", {383'd0, bus.sat_flag}, 384'd1);
      beat(1, 1'b1, 1'b0, lane0v(-8388000));
      beat(1, 1'b0, 1'b0, lane0v(-1000));
      chk("t3_sat_neg", {383'd0, bus.sat_flag}, 384'd1);
      beat(15, 1'b0, 1'b1, '0);
      drain(-1, -1);
      chk("t3_row0_lane0", {360'd0, lane(cap[0], 0)}, {360'd0, 24'h7FFFFF});
      chk("t3_row1_lane0", {360'd0, lane(cap[1], 0)}, {360'd0, 24'h800000});
      chk("t3_row5_kept", {360'd0, lane(cap[5], 0)}, 384'd580);
      chk("t3_row7_kept", {360'd0, lane(cap[7], 0)}, 384'd612);
      wait_phase(1'b0, 1'b1);

      // tile 4: reset at drain beat 7, then a fresh tile
      for (int r = 0; r < 16; r++) beat(r, 1'b1, r == 15, pat(r, 2000));
      drain(-1, 7);
      for (int r = 0; r < 16; r++) beat(r, 1'b1, r == 15, pat(r, 0));
      drain(-1, -1);
      chk("t5_row0_lane0", {360'd0, lane(cap[0], 0)}, 384'd0);
      chk("t5_row15_lane15", {360'd0, lane(cap[15], 15)}, 384'd255);
      wait_phase(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/psum_streamer.md
PSUM_STREAMER -- requirements
Module: psum_streamer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 acc_valid  input  1  array-side beat valid.
REQ-005 acc_data  input  384  16 lanes x 24-bit signed partial sums; lane j at [j*24 +: 24].
REQ-006 acc_row  input  4  buffer row (0..15) targeted by the beat.
REQ-007 acc_first  input  1  overwrite row instead of accumulate (first K-tile).
REQ-008 acc_last  input  1  final K-tile marker.
REQ-009 acc_ready  output  1  beat accepted when acc_valid && acc_ready at a clock edge.
REQ-010 ppu_done  input  1  downstream post-processing finished with the last burst.
REQ-011 partial_sum  output  384  row data toward the post-processing unit.
REQ-012 valid  output  1  partial_sum beat valid.
REQ-013 busy  output  1  high whenever state is not ACCUM.
REQ-014 sat_flag  output  1  sticky: some lane saturated since the last WAIT exit.

Function
REQ-015 SHALL hold a 16-row x 384-bit accumulation buffer, a 4-bit drain counter, and a state machine with states ACCUM, DRAIN and WAIT.
REQ-016 ACCUM: acc_ready=1, valid=0, partial_sum=0.
REQ-017 On an accepted beat, buf[acc_row] SHALL be set to acc_data if acc_first=1; otherwise each lane SHALL be the signed 25-bit sum buf+acc_data, saturated to [-8388608, 8388607].
REQ-018 Any lane saturating on an accepted beat SHALL set sat_flag at that edge.
REQ-019 An accepted beat with acc_last=1 and acc_row=15 SHALL perform its write and move the state to DRAIN at the same edge; acc_last with acc_row!=15 SHALL only accumulate.
REQ-020 DRAIN: acc_ready=0; for exactly 16 consecutive cycles, starting the cycle after the accepting edge, valid=1 and partial_sum=buf[k] for k=0..15 in order; outputs registered; the row-15 write of the accepting beat SHALL be visible.
REQ-021 After the beat for row 15, the state SHALL be WAIT, with valid=0 and partial_sum=0 in the following cycle.
REQ-022 WAIT: acc_ready=0, valid=0; ppu_done=1 at an edge SHALL return the state to ACCUM and clear sat_flag.
REQ-023 ppu_done SHALL be ignored in ACCUM and DRAIN.
REQ-024 acc_valid while acc_ready=0 SHALL be dropped with no buffer, flag or state change.
REQ-025 Buffer contents SHALL be retained after a drain; a new tile starts with acc_first beats.
REQ-026 Drain counter SHALL wrap 15->0 on leaving DRAIN; no other wrap exists.

Reset
REQ-027 On rst_n=0, asynchronously: state=ACCUM, buffer=0, counter=0, valid=0, partial_sum=0, sat_flag=0, busy=0, acc_ready=1.
REQ-028 Reset asserted mid-DRAIN or in WAIT SHALL abort the burst immediately with no further valid beats.

Verification
REQ-029 Write rows 0..15 with acc_first=1, lane values row*16+lane, acc_last on row 15 -> valid high for exactly 16 cycles starting the next cycle, beat k lane j = k*16+j, busy=1, acc_ready=0.
REQ-030 Row 3 acc_first=1 with 100, then row 3 accumulate with -30, then complete the tile -> drained row 3 lanes = 70.
REQ-031 Row 0 lane 0 = 8388000 plus 1000, and a second case -8388000 plus -1000 -> 8388607 and -8388608, sat_flag=1 until ppu_done in WAIT.
REQ-032 acc_valid pulsed during DRAIN and WAIT -> buffer unchanged in the next tile's drain; ppu_done pulsed during DRAIN -> ignored, WAIT still entered.
REQ-033 rst_n low at drain beat 7 -> valid=0 asynchronously, state ACCUM, acc_ready=1; a full fresh tile then drains correctly from row 0.
